// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults and port-slicing helpers for regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DBITS_DEFAULT = 32;
    localparam int c_ABITS_DEFAULT = 4;
    localparam int c_NRD_DEFAULT   = 2;

    // Low bit of port `port` inside a flattened bus of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/busy_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : busy_scoreboard
// Brief    : Per-register pending bits with a registered population count.
// Revision : 1.0 - initial release
// ============================================================================
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int ABITS    = c_ABITS_DEFAULT,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ABITS-1:0]      i_wr_idx,
    input  logic                  i_claim_en,
    input  logic [ABITS-1:0]      i_claim_idx,
    output logic [(2**ABITS)-1:0] o_busy,
    output logic [ABITS:0]        o_busy_cnt
);

    localparam int c_words = 2**ABITS;

    logic [c_words-1:0] r_busy;
    logic [c_words-1:0] w_busy_nxt;
    logic [ABITS:0]     r_cnt;
    logic [ABITS:0]     w_cnt_nxt;

    // Claim is applied after the write so a same-index claim wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wr_en) begin
            w_busy_nxt[i_wr_idx] = 1'b0;
        end
        if (i_claim_en) begin
            w_busy_nxt[i_claim_idx] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < c_words; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ABITS{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-read-port register file with write bypass and busy tracking.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DBITS    = c_DBITS_DEFAULT,
    parameter int ABITS    = c_ABITS_DEFAULT,
    parameter int NRD      = c_NRD_DEFAULT,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ABITS-1:0]     wr_idx,
    input  logic [DBITS-1:0]     wr_data,
    input  logic [NRD*ABITS-1:0] rd_idx,
    output logic [NRD*DBITS-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 claim_en,
    input  logic [ABITS-1:0]     claim_idx,
    output logic [ABITS:0]       busy_cnt
);

    localparam int c_words = 2**ABITS;

    logic [DBITS-1:0]   r_mem [c_words];
    logic [c_words-1:0] w_busy;
    logic               w_wr_accept;

    assign w_wr_accept = wr_en && !((ZERO_REG != 0) && (wr_idx == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_words; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    busy_scoreboard #(
        .ABITS    (ABITS),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_idx    (wr_idx),
        .i_claim_en  (claim_en),
        .i_claim_idx (claim_idx),
        .o_busy      (w_busy),
        .o_busy_cnt  (busy_cnt)
    );

    // Bypass compares raw wr_en so it stays live while reset is held.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            localparam int c_ilo = slice_lo(k, ABITS);
            localparam int c_dlo = slice_lo(k, DBITS);

            logic [ABITS-1:0] w_idx;
            logic             w_zero;
            logic             w_hit;

            assign w_idx  = rd_idx[c_ilo +: ABITS];
            assign w_zero = (ZERO_REG != 0) && (w_idx == '0);
            assign w_hit  = wr_en && (w_idx == wr_idx);

            assign rd_data[c_dlo +: DBITS] = w_zero ? '0      :
                                             w_hit  ? wr_data :
                                                      r_mem[w_idx];
            assign rd_busy[k] = w_busy[w_idx];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed table, reset sequences and randomized model checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic [7:0]  rd_idx;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        claim_en;
    logic [3:0]  claim_idx;
    logic [4:0]  busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: register contents and the set of pending indices.
    logic [31:0] m_mem [16];
    bit          m_busy [int];

    regfile_scoreboard #(
        .DBITS    (32),
        .ABITS    (4),
        .NRD      (2),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .claim_en  (claim_en),
        .claim_idx (claim_idx),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  wi;
        logic [31:0] wd;
        logic        ce;
        logic [3:0]  ci;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [4:0]  ec;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic we, input logic [3:0] wi, input logic [31:0] wd,
                         input logic ce, input logic [3:0] ci,
                         input logic [3:0] r0, input logic [3:0] r1);
        wr_en     = we;
        wr_idx    = wi;
        wr_data   = wd;
        claim_en  = ce;
        claim_idx = ci;
        rd_idx    = {r1, r0};
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_busy.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (wr_en && wr_idx != 4'd0) begin
                m_mem[wr_idx] = wr_data;
                m_busy.delete(int'(wr_idx));
            end
            if (claim_en && claim_idx != 4'd0) m_busy[int'(claim_idx)] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  idx;
        logic [31:0] e;
        for (int k = 0; k < 2; k++) begin
            idx = rd_idx[k*4 +: 4];
            if (idx == 4'd0)                      e = '0;
            else if (wr_en && wr_idx == idx)      e = wr_data;
            else                                  e = m_mem[idx];
            chk($sformatf("%s rd_data[%0d] idx%0d", tag, k, idx), 64'(rd_data[k*32 +: 32]), 64'(e));
            chk($sformatf("%s rd_busy[%0d] idx%0d", tag, k, idx), 64'(rd_busy[k]),
                m_busy.exists(int'(idx)) ? 64'd1 : 64'd0);
        end
        chk($sformatf("%s busy_cnt", tag), 64'(busy_cnt), 64'(m_busy.num()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 5'd0};
        tbl[1]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0,        2'b00, 5'd0};
        tbl[2]  = '{1'b1, 4'd0, 32'h1234,     1'b0, 4'd0, 4'd0, 4'd5, 32'h0,        32'hDEADBEEF, 2'b00, 5'd0};
        tbl[3]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 5'd0};
        tbl[4]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd3, 4'd3, 4'd0, 32'h0,        32'h0,        2'b00, 5'd0};
        tbl[5]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 4'd3, 4'd7, 32'h0,        32'h0,        2'b01, 5'd1};
        tbl[6]  = '{1'b1, 4'd3, 32'h33,       1'b0, 4'd0, 4'd3, 4'd7, 32'h33,       32'h0,        2'b11, 5'd2};
        tbl[7]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd7, 4'd3, 32'h0,        32'h33,       2'b01, 5'd1};
        tbl[8]  = '{1'b1, 4'd9, 32'h9999,     1'b1, 4'd9, 4'd9, 4'd7, 32'h9999,     32'h0,        2'b10, 5'd1};
        tbl[9]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd9, 4'd5, 32'h9999,     32'hDEADBEEF, 2'b01, 5'd2};
        tbl[10] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd9, 4'd9, 4'd3, 32'h9999,     32'h33,       2'b01, 5'd2};
        tbl[11] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd9, 4'd7, 32'h9999,     32'h0,        2'b11, 5'd2};
        tbl[12] = '{1'b1, 4'd5, 32'h55,       1'b0, 4'd0, 4'd5, 4'd5, 32'h55,       32'h55,       2'b00, 5'd2};
        tbl[13] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd5, 4'd9, 32'h55,       32'h9999,     2'b10, 5'd2};

        rst_n = 1'b0;
        model_clear();
        apply(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset sweep of every index on both ports.
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 0, 0, 0, 4'(i), 4'(15 - i));
            chk($sformatf("reset rd_data0 idx%0d", i), 64'(rd_data[31:0]), 64'd0);
            chk($sformatf("reset rd_data1 idx%0d", i), 64'(rd_data[63:32]), 64'd0);
            chk($sformatf("reset rd_busy idx%0d", i), 64'(rd_busy), 64'd0);
            chk($sformatf("reset busy_cnt idx%0d", i), 64'(busy_cnt), 64'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].we, tbl[i].wi, tbl[i].wd, tbl[i].ce, tbl[i].ci, tbl[i].r0, tbl[i].r1);
            chk($sformatf("row%0d rd_data0", i), 64'(rd_data[31:0]), 64'(tbl[i].e0));
            chk($sformatf("row%0d rd_data1", i), 64'(rd_data[63:32]), 64'(tbl[i].e1));
            chk($sformatf("row%0d rd_busy", i), 64'(rd_busy), 64'(tbl[i].eb));
            chk($sformatf("row%0d busy_cnt", i), 64'(busy_cnt), 64'(tbl[i].ec));
            tick();
        end

        // Asynchronous reset with r2/r4 busy and holding data.
        apply(1, 2, 32'h2222, 1, 2, 2, 4);
        tick();
        apply(1, 4, 32'h4444, 1, 4, 2, 4);
        tick();
        apply(0, 0, 0, 0, 0, 2, 4);
        chk("prereset rd_data", rd_data, 64'h0000_4444_0000_2222);
        chk("prereset rd_busy", 64'(rd_busy), 64'd3);
        check_model("prereset");
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async rst rd_data", rd_data, 64'd0);
        chk("async rst rd_busy", 64'(rd_busy), 64'd0);
        chk("async rst busy_cnt", 64'(busy_cnt), 64'd0);

        // Write and claim presented across an edge with reset still held.
        @(negedge clk);
        apply(1, 6, 32'hA5A5, 1, 6, 6, 2);
        chk("in-reset bypass rd_data0", 64'(rd_data[31:0]), 64'hA5A5);
        chk("in-reset rd_data1", 64'(rd_data[63:32]), 64'd0);
        chk("in-reset rd_busy", 64'(rd_busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 6, 2);
        chk("after reset r6 data", 64'(rd_data[31:0]), 64'd0);
        chk("after reset r6 busy", 64'(rd_busy), 64'd0);
        chk("after reset busy_cnt", 64'(busy_cnt), 64'd0);
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                  1'($urandom_range(0, 2) == 0), 4'($urandom),
                  4'($urandom), 4'($urandom));
            check_model($sformatf("rand%0d", n));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DBITS, default 32, data width in bits.
REQ-002 SHALL have parameter ABITS, default 4, register index width; register count WORDS = 2**ABITS.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads zero and ignores writes and claims.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port wr_en, input, 1, write strobe.
REQ-008 SHALL have port wr_idx, input, ABITS, write register index.
REQ-009 SHALL have port wr_data, input, DBITS, write data.
REQ-010 SHALL have port rd_idx, input, NRD*ABITS, read indices; port k in bits [k*ABITS +: ABITS].
REQ-011 SHALL have port rd_data, output, NRD*DBITS, read data; port k in bits [k*DBITS +: DBITS].
REQ-012 SHALL have port rd_busy, output, NRD, busy flag of each read port's register.
REQ-013 SHALL have port claim_en, input, 1, mark destination register pending.
REQ-014 SHALL have port claim_idx, input, ABITS, register index to claim.
REQ-015 SHALL have port busy_cnt, output, ABITS+1, registered count of busy registers.

Function
REQ-016 SHALL write wr_data to register wr_idx on a rising clk edge when wr_en=1.
REQ-017 SHALL drive rd_data combinationally, zero cycles from rd_idx.
REQ-018 SHALL bypass: when wr_en=1 and rd_idx[k]==wr_idx (non-zero, or any index if ZERO_REG=0), rd_data[k] = wr_data in that cycle.
REQ-019 SHALL, when ZERO_REG=1, return 0 for index 0 regardless of bypass, and never set busy[0].
REQ-020 SHALL keep one busy bit per register: claim_en sets busy[claim_idx]; wr_en clears busy[wr_idx], both on the next edge.
REQ-021 SHALL, when claim and write target the same index in one cycle, leave busy=1, because the claim wins.
REQ-022 SHALL accept a claim of an already-busy register; busy stays 1 and busy_cnt is unchanged.
REQ-023 SHALL accept a write to a non-busy register; the data updates and busy stays 0.
REQ-024 SHALL drive rd_busy[k] = busy[rd_idx[k]] from registered state, with no bypass of the same-cycle claim or write.
REQ-025 SHALL make busy_cnt equal to the population count of the busy bits after each edge, ranging 0..WORDS (or WORDS-1 when ZERO_REG=1).
REQ-026 SHALL let all NRD read ports address the same or different registers independently in the same cycle.

Reset
REQ-027 SHALL, while rst_n=0, immediately clear all registers to 0, all busy bits to 0 and busy_cnt to 0, independent of clk.
REQ-028 SHALL discard any write or claim presented in the cycle rst_n deasserts only if rst_n is still low at that edge.
REQ-029 SHALL force rd_data to 0 and rd_busy to 0 during reset, except for same-cycle bypass data, which follows REQ-018.

Structure
REQ-030 SHALL place default DBITS/ABITS/NRD values and the index-slicing helper constants in shared package regfile_pkg.
REQ-031 SHALL implement the busy bit vector and busy_cnt in sub-module busy_scoreboard; the data array and bypass muxes stay in the top module.
REQ-032 SHALL use an array of WORDS entries, indexed 0..WORDS-1.

Verification
REQ-033 SHALL cover: reset, then read all 16 indices on both ports -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-034 SHALL cover: write 0xDEADBEEF to r5 while rd_idx[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF in that cycle and after the edge.
REQ-035 SHALL cover: write 0x1234 to r0 with ZERO_REG=1, then read r0 -> 0; claim r0 -> busy_cnt stays 0.
REQ-036 SHALL cover: claim r3, then claim r7, then write r3 -> busy_cnt goes 1, 2, 1; rd_busy for r7 = 1 and for r3 = 0.
REQ-037 SHALL cover: claim r9 and write r9 in the same cycle -> busy[9]=1, r9 holds the new data, busy_cnt +1.
REQ-038 SHALL cover: busy r2 and r4 holding data, rst_n pulsed low mid-cycle with no clk edge -> all outputs 0 immediately.
